// File: rtl/match_controller.sv
// Match sequencer for pong: serve, rally, scoring, frame-counted pause, game over and restart.
// Next state is computed combinationally; every output comes straight from a register.
module match_controller #(
  parameter int SCORE_WIDTH  = 4,
  parameter int WIN_SCORE    = 11,
  parameter int WIN_BY_TWO   = 1,
  parameter int PAUSE_FRAMES = 60,
  parameter int SERVE_MODE   = 0
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_vsync_pulse,
  input  logic                   i_left_ckick,
  input  logic                   i_right_ckick,
  input  logic                   i_left_miss,
  input  logic                   i_right_miss,
  output logic                   o_left_will_start,
  output logic                   o_right_will_start,
  output logic                   o_ball_in_game,
  output logic [SCORE_WIDTH-1:0] o_left_score,
  output logic [SCORE_WIDTH-1:0] o_right_score,
  output logic                   o_game_over,
  output logic                   o_winner,
  output logic [2:0]             o_state
);

  typedef enum logic [2:0] {
    SERVE_R = 3'd0,
    SERVE_L = 3'd1,
    PLAY    = 3'd2,
    PAUSE   = 3'd3,
    OVER    = 3'd4
  } state_e;

  localparam int PW = (PAUSE_FRAMES < 2) ? 1 : $clog2(PAUSE_FRAMES + 1);
  localparam logic [PW-1:0] PAUSE_LAST = PW'((PAUSE_FRAMES > 0) ? PAUSE_FRAMES - 1 : 0);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = {SCORE_WIDTH{1'b1}};

  state_e                 state_q, state_d;
  logic [SCORE_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic                   winner_q, winner_d;
  logic [PW-1:0]          cnt_q, cnt_d;
  // Player encoding for the server registers: 1 = right, 0 = left (same as o_winner).
  logic                   last_srv_q, last_srv_d;
  logic                   next_srv_q, next_srv_d;
  logic [SCORE_WIDTH-1:0] left_up, right_up;
  logic                   left_wins, right_wins;

  // Extra top bit keeps q+2 from overflowing; reaching the max score always wins so scores never wrap.
  function automatic logic wins(input logic [SCORE_WIDTH-1:0] p, input logic [SCORE_WIDTH-1:0] q);
    logic [SCORE_WIDTH:0] pe;
    logic [SCORE_WIDTH:0] qe;
    pe = {1'b0, p};
    qe = {1'b0, q};
    return ((pe >= (SCORE_WIDTH+1)'(WIN_SCORE)) &&
            ((WIN_BY_TWO == 0) || (pe >= qe + (SCORE_WIDTH+1)'(2)))) ||
           (p == SCORE_MAX);
  endfunction

  assign left_up    = left_q + SCORE_WIDTH'(1);
  assign right_up   = right_q + SCORE_WIDTH'(1);
  assign left_wins  = wins(left_up, right_q);
  assign right_wins = wins(right_up, left_q);

  always_comb begin
    state_d    = state_q;
    left_d     = left_q;
    right_d    = right_q;
    winner_d   = winner_q;
    cnt_d      = cnt_q;
    last_srv_d = last_srv_q;
    next_srv_d = next_srv_q;
    case (state_q)
      SERVE_R: if (i_right_ckick) state_d = PLAY;
      SERVE_L: if (i_left_ckick) state_d = PLAY;
      PLAY: begin
        if (i_left_miss && i_right_miss) begin
          state_d    = PAUSE;
          cnt_d      = '0;
          next_srv_d = last_srv_q;
        end else if (i_left_miss) begin
          right_d = right_up;
          if (right_wins) begin
            state_d  = OVER;
            winner_d = 1'b1;
          end else begin
            state_d    = PAUSE;
            cnt_d      = '0;
            next_srv_d = (SERVE_MODE != 0) ? ~last_srv_q : 1'b0;
          end
        end else if (i_right_miss) begin
          left_d = left_up;
          if (left_wins) begin
            state_d  = OVER;
            winner_d = 1'b0;
          end else begin
            state_d    = PAUSE;
            cnt_d      = '0;
            next_srv_d = (SERVE_MODE != 0) ? ~last_srv_q : 1'b1;
          end
        end
      end
      PAUSE: begin
        if ((PAUSE_FRAMES == 0) || (i_vsync_pulse && (cnt_q == PAUSE_LAST))) begin
          state_d    = next_srv_q ? SERVE_R : SERVE_L;
          last_srv_d = next_srv_q;
        end else if (i_vsync_pulse) begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      OVER: begin
        if (i_left_ckick || i_right_ckick) begin
          left_d     = '0;
          right_d    = '0;
          state_d    = winner_q ? SERVE_L : SERVE_R;
          last_srv_d = ~winner_q;
        end
      end
      default: state_d = SERVE_R;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q            <= SERVE_R;
      left_q             <= '0;
      right_q            <= '0;
      winner_q           <= 1'b0;
      cnt_q              <= '0;
      last_srv_q         <= 1'b1;
      next_srv_q         <= 1'b1;
      o_right_will_start <= 1'b1;
      o_left_will_start  <= 1'b0;
      o_ball_in_game     <= 1'b0;
      o_game_over        <= 1'b0;
    end else begin
      state_q            <= state_d;
      left_q             <= left_d;
      right_q            <= right_d;
      winner_q           <= winner_d;
      cnt_q              <= cnt_d;
      last_srv_q         <= last_srv_d;
      next_srv_q         <= next_srv_d;
      o_right_will_start <= (state_d == SERVE_R);
      o_left_will_start  <= (state_d == SERVE_L);
      o_ball_in_game     <= (state_d == PLAY);
      o_game_over        <= (state_d == OVER);
    end
  end

  assign o_left_score  = left_q;
  assign o_right_score = right_q;
  assign o_winner      = winner_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench: default match controller (11 points, win by two, 60-frame pause) plus a
// 2-bit saturating variant with no pause and alternating serve.
module tb_match_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 1: defaults
  logic       vs1 = 0, lk1 = 0, rk1 = 0, lm1 = 0, rm1 = 0;
  logic       lws1, rws1, big1, go1, win1;
  logic [3:0] ls1, rs1;
  logic [2:0] st1;

  match_controller dut1 (
    .i_clock(clk), .i_reset(rst), .i_vsync_pulse(vs1),
    .i_left_ckick(lk1), .i_right_ckick(rk1), .i_left_miss(lm1), .i_right_miss(rm1),
    .o_left_will_start(lws1), .o_right_will_start(rws1), .o_ball_in_game(big1),
    .o_left_score(ls1), .o_right_score(rs1), .o_game_over(go1), .o_winner(win1),
    .o_state(st1)
  );

  // Instance 2: SCORE_WIDTH=2, WIN_SCORE=2, win by two, no pause, alternating serve
  logic       vs2 = 0, lk2 = 0, rk2 = 0, lm2 = 0, rm2 = 0;
  logic       lws2, rws2, big2, go2, win2;
  logic [1:0] ls2, rs2;
  logic [2:0] st2;

  match_controller #(.SCORE_WIDTH(2), .WIN_SCORE(2), .WIN_BY_TWO(1),
                     .PAUSE_FRAMES(0), .SERVE_MODE(1)) dut2 (
    .i_clock(clk), .i_reset(rst), .i_vsync_pulse(vs2),
    .i_left_ckick(lk2), .i_right_ckick(rk2), .i_left_miss(lm2), .i_right_miss(rm2),
    .o_left_will_start(lws2), .o_right_will_start(rws2), .o_ball_in_game(big2),
    .o_left_score(ls2), .o_right_score(rs2), .o_game_over(go2), .o_winner(win2),
    .o_state(st2)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold the given inputs for one cycle on the selected instance; returns on the next negedge.
  task automatic step(input bit sel, input logic lk, input logic rk,
                      input logic lm, input logic rm, input logic vs);
    if (!sel) begin lk1 = lk; rk1 = rk; lm1 = lm; rm1 = rm; vs1 = vs; end
    else      begin lk2 = lk; rk2 = rk; lm2 = lm; rm2 = rm; vs2 = vs; end
    @(negedge clk);
    lk1 = 0; rk1 = 0; lm1 = 0; rm1 = 0; vs1 = 0;
    lk2 = 0; rk2 = 0; lm2 = 0; rm2 = 0; vs2 = 0;
  endtask

  task automatic vsyncs(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic chk_scores1(input string tag, input int l, input int r);
    chk({tag, "_ls"}, 32'(ls1), 32'(l));
    chk({tag, "_rs"}, 32'(rs1), 32'(r));
  endtask

  task automatic chk_scores2(input string tag, input int l, input int r);
    chk({tag, "_ls"}, 32'(ls2), 32'(l));
    chk({tag, "_rs"}, 32'(rs2), 32'(r));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset values
    chk("rst_state", 32'(st1), 0);
    chk("rst_rws", 32'(rws1), 1);
    chk("rst_lws", 32'(lws1), 0);
    chk("rst_ball", 32'(big1), 0);
    chk("rst_over", 32'(go1), 0);
    chk("rst_win", 32'(win1), 0);
    chk_scores1("rst", 0, 0);

    // Serve and first point
    step(0, 0, 1, 0, 0, 0);
    chk("serve_state", 32'(st1), 2);
    chk("serve_ball", 32'(big1), 1);
    chk_scores1("serve", 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("play_kick_ignored", 32'(st1), 2);
    step(0, 0, 0, 1, 0, 0);
    chk("lmiss_state", 32'(st1), 3);
    chk_scores1("lmiss", 0, 1);
    vsyncs(59);
    chk("pause_59", 32'(st1), 3);
    vsyncs(1);
    chk("pause_60_state", 32'(st1), 1);
    chk("pause_60_lws", 32'(lws1), 1);

    // Double miss: replay by left
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    chk("dbl_state", 32'(st1), 3);
    chk_scores1("dbl", 0, 1);
    vsyncs(60);
    chk("dbl_replay", 32'(st1), 1);

    // Reset mid-pause after 30 frames
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk_scores1("pre_rst", 1, 1);
    vsyncs(30);
    chk("pre_rst_state", 32'(st1), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_state", 32'(st1), 0);
    chk("midrst_rws", 32'(rws1), 1);
    chk_scores1("midrst", 0, 0);

    // Misses ignored while serving
    step(0, 0, 0, 1, 1, 0);
    chk("serve_miss_ignored", 32'(st1), 0);
    chk_scores1("serve_miss", 0, 0);

    // Alternate points up to 10/10
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      vsyncs(60);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      vsyncs(60);
    end
    chk("ten_state", 32'(st1), 0);
    chk_scores1("ten", 10, 10);

    // Win by two
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("r11_state", 32'(st1), 3);
    chk_scores1("r11", 10, 11);
    vsyncs(60);
    chk("r11_serve", 32'(st1), 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("r12_state", 32'(st1), 4);
    chk("r12_over", 32'(go1), 1);
    chk("r12_winner", 32'(win1), 1);
    chk_scores1("r12", 10, 12);
    step(0, 0, 0, 1, 1, 1);
    chk("over_hold", 32'(st1), 4);
    chk_scores1("over_hold", 10, 12);
    step(0, 0, 1, 0, 0, 0);
    chk("restart_state", 32'(st1), 1);
    chk("restart_lws", 32'(lws1), 1);
    chk("restart_over", 32'(go1), 0);
    chk_scores1("restart", 0, 0);

    // Instance 2: saturation win, zero pause, alternating serve
    chk("b_rst_state", 32'(st2), 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("b_p1_state", 32'(st2), 3);
    chk_scores2("b_p1", 0, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("b_p1_serve", 32'(st2), 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("b_p2_serve", 32'(st2), 0);
    chk_scores2("b_p2", 1, 1);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("b_p3_state", 32'(st2), 3);
    step(1, 0, 0, 0, 0, 0);
    chk("b_p3_serve", 32'(st2), 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("b_p4_state", 32'(st2), 3);
    chk_scores2("b_p4", 2, 2);
    step(1, 0, 0, 0, 0, 0);
    chk("b_p4_serve", 32'(st2), 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("b_sat_state", 32'(st2), 4);
    chk("b_sat_winner", 32'(win2), 0);
    chk("b_sat_over", 32'(go2), 1);
    chk_scores2("b_sat", 3, 2);
    step(1, 0, 0, 0, 1, 0);
    chk_scores2("b_sat_hold", 3, 2);
    step(1, 1, 0, 0, 0, 0);
    chk("b_restart_state", 32'(st2), 0);
    chk("b_restart_rws", 32'(rws2), 1);
    chk_scores2("b_restart", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
